// File: rtl/kj_stream_fifo_pkg.sv
// Shared width helpers and lane-slice helper for the K-in/J-out stream FIFO.
package fifo_pkg;

    // Pointer width; a 1-deep ring still needs one pointer bit.
    function automatic int ptr_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    function automatic int cnt_w(input int size);
        return $clog2(size + 1);
    endfunction

    function automatic int num_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    // Low bit of word i in a packed multi-word bus.
    function automatic int lane_lo(input int i, input int width);
        return i * width;
    endfunction

endpackage

// File: rtl/kj_stream_fifo_if.sv
// Write/read handshake bundle between a K-lane producer, the FIFO and a J-lane consumer.
interface kj_stream_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int J     = 4
) ();
    localparam int NW = num_w(K);
    localparam int RW = num_w(J);

    logic               wr_valid;
    logic [NW-1:0]      wr_num;
    logic [WIDTH*K-1:0] wr_data;
    logic               wr_ready;
    logic               rd_valid;
    logic               rd_ready;
    logic               drain;
    logic [RW-1:0]      rd_num;
    logic [WIDTH*J-1:0] rd_data;

    modport master (
        output wr_valid, wr_num, wr_data, rd_ready, drain,
        input  wr_ready, rd_valid, rd_num, rd_data
    );

    modport slave (
        input  wr_valid, wr_num, wr_data, rd_ready, drain,
        output wr_ready, rd_valid, rd_num, rd_data
    );
endinterface

// File: rtl/kj_stream_fifo_ring_index_add.sv
// (idx + n) mod SIZE without a divider; valid for idx < SIZE and n <= SIZE.
module ring_index_add #(
    parameter int SIZE = 16,
    parameter int BIT  = 4,
    parameter int NW   = 3
) (
    input  logic [BIT-1:0] idx,
    input  logic [NW-1:0]  n,
    output logic [BIT-1:0] sum
);
    localparam int SW = ((BIT > NW) ? BIT : NW) + 1;

    logic [SW-1:0] raw;

    assign raw = SW'(idx) + SW'(n);
    assign sum = (raw >= SW'(SIZE)) ? BIT'(raw - SW'(SIZE)) : BIT'(raw);
endmodule

// File: rtl/kj_stream_fifo.sv
// K-in/J-out ring-buffer FIFO with first-word fall-through reads, partial drain,
// flush and occupancy flags. Every slot is usable; fullness comes from count.
module kj_stream_fifo
    import fifo_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int WIDTH    = 8,
    parameter int K        = 4,
    parameter int J        = 4,
    parameter int AF_LEVEL = SIZE - K,
    localparam int BIT     = ptr_w(SIZE),
    localparam int CW      = cnt_w(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    kj_stream_fifo_if.slave  s,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             err
);
    localparam int NW = num_w(K);
    localparam int RW = num_w(J);

    logic [WIDTH-1:0]          mem [SIZE];
    logic [BIT-1:0]            wptr, rptr, wptr_nxt, rptr_nxt;
    logic [BIT-1:0]            waddr [K];
    logic [BIT-1:0]            raddr [J];
    logic [J-1:0][WIDTH-1:0]   rd_lanes;
    logic [CW-1:0]             free;
    logic [RW-1:0]             rn_sel;
    logic [NW-1:0]             wn;
    logic [RW-1:0]             rn;
    logic                      wr_legal, wr_fire, rd_fire;

    // Write space comes from registered count only, so a same-cycle read never opens room.
    assign free       = CW'(SIZE) - count;
    assign wr_legal   = (s.wr_num != '0) && (int'(s.wr_num) <= K);
    assign s.wr_ready = (int'(free) >= int'(s.wr_num));
    assign wr_fire    = s.wr_valid && s.wr_ready && wr_legal;
    assign wn         = wr_fire ? s.wr_num : '0;

    always_comb begin
        rn_sel = '0;
        if (int'(count) >= J)
            rn_sel = RW'(J);
        else if (s.drain)
            rn_sel = RW'(count);
    end

    assign s.rd_num   = rn_sel;
    assign s.rd_valid = (rn_sel != '0);
    assign rd_fire    = s.rd_valid && s.rd_ready;
    assign rn         = rd_fire ? rn_sel : '0;
    assign s.rd_data  = rd_lanes;

    ring_index_add #(.SIZE(SIZE), .BIT(BIT), .NW(NW)) u_wadv (
        .idx(wptr), .n(s.wr_num), .sum(wptr_nxt)
    );
    ring_index_add #(.SIZE(SIZE), .BIT(BIT), .NW(RW)) u_radv (
        .idx(rptr), .n(rn_sel), .sum(rptr_nxt)
    );

    for (genvar i = 0; i < K; i++) begin : g_wlane
        ring_index_add #(.SIZE(SIZE), .BIT(BIT), .NW(NW)) u_addr (
            .idx(wptr), .n(NW'(i)), .sum(waddr[i])
        );
    end

    for (genvar i = 0; i < J; i++) begin : g_rlane
        ring_index_add #(.SIZE(SIZE), .BIT(BIT), .NW(RW)) u_addr (
            .idx(rptr), .n(RW'(i)), .sum(raddr[i])
        );
        assign rd_lanes[i] = (RW'(i) < rn_sel) ? mem[raddr[i]] : '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < K; i++) begin
            if (!rst && !flush && wr_fire && (i < int'(s.wr_num)))
                mem[waddr[i]] <= s.wr_data[lane_lo(i, WIDTH) +: WIDTH];
        end
    end

    // Flush clears pointers and count but deliberately leaves the sticky err alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (s.wr_valid && !wr_legal)
                err <= 1'b1;
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (wr_fire) wptr <= wptr_nxt;
                if (rd_fire) rptr <= rptr_nxt;
                count <= count + CW'(wn) - CW'(rn);
            end
        end
    end

    assign full        = (count == CW'(SIZE));
    assign empty       = (count == '0);
    assign almost_full = (int'(count) >= AF_LEVEL);
endmodule

// File: tb/tb_kj_stream_fifo.sv
// Bench for kj_stream_fifo: vector table and corner sequences on SIZE=16/12,
// then random traffic against a queue reference model on both sizes.
module tb_kj_stream_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0, flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0, drain = 1'b0;
    logic [2:0]  wr_num = '0;
    logic [31:0] wr_data = '0;
    int          sel = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    kj_stream_fifo_if #(.WIDTH(8), .K(4), .J(4)) bus16 ();
    kj_stream_fifo_if #(.WIDTH(8), .K(4), .J(4)) bus12 ();

    assign bus16.wr_valid = wr_valid;  assign bus12.wr_valid = wr_valid;
    assign bus16.wr_num   = wr_num;    assign bus12.wr_num   = wr_num;
    assign bus16.wr_data  = wr_data;   assign bus12.wr_data  = wr_data;
    assign bus16.rd_ready = rd_ready;  assign bus12.rd_ready = rd_ready;
    assign bus16.drain    = drain;     assign bus12.drain    = drain;

    logic [4:0] count16;
    logic [3:0] count12;
    logic full16, empty16, af16, err16, full12, empty12, af12, err12;

    kj_stream_fifo #(.SIZE(16), .WIDTH(8), .K(4), .J(4)) dut16 (
        .clk(clk), .rst(rst), .flush(flush), .s(bus16), .count(count16),
        .full(full16), .empty(empty16), .almost_full(af16), .err(err16));

    kj_stream_fifo #(.SIZE(12), .WIDTH(8), .K(4), .J(4)) dut12 (
        .clk(clk), .rst(rst), .flush(flush), .s(bus12), .count(count12),
        .full(full12), .empty(empty12), .almost_full(af12), .err(err12));

    logic        m_wrr, m_rdv, m_full, m_empty, m_af, m_err;
    logic [2:0]  m_rdn;
    logic [31:0] m_rdd;
    logic [4:0]  m_cnt;

    always_comb begin
        if (sel == 0) begin
            m_wrr = bus16.wr_ready; m_rdv = bus16.rd_valid; m_rdn = bus16.rd_num;
            m_rdd = bus16.rd_data;  m_cnt = count16;        m_full = full16;
            m_empty = empty16;      m_af = af16;            m_err = err16;
        end else begin
            m_wrr = bus12.wr_ready; m_rdv = bus12.rd_valid; m_rdn = bus12.rd_num;
            m_rdd = bus12.rd_data;  m_cnt = {1'b0, count12}; m_full = full12;
            m_empty = empty12;      m_af = af12;            m_err = err12;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 0; wr_num = 0; wr_data = 0; rd_ready = 0; drain = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic put(input logic [2:0] n, input logic [31:0] d);
        wr_valid = 1; wr_num = n; wr_data = d;
        tick();
        wr_valid = 0;
    endtask

    typedef struct {
        logic        wv;
        logic [2:0]  wn;
        logic [31:0] wd;
        logic        rr, dr, fl;
        logic        e_wrr;
        logic [2:0]  e_rdn;
        logic [31:0] e_rdd;
        int          e_cnt;
        logic        e_full, e_af, e_empty;
    } vec_t;

    function automatic vec_t mk(input logic wv, input logic [2:0] wn, input logic [31:0] wd,
                                input logic rr, input logic dr, input logic fl,
                                input logic e_wrr, input logic [2:0] e_rdn, input logic [31:0] e_rdd,
                                input int e_cnt, input logic e_full, input logic e_af, input logic e_empty);
        vec_t v;
        v.wv = wv; v.wn = wn; v.wd = wd; v.rr = rr; v.dr = dr; v.fl = fl;
        v.e_wrr = e_wrr; v.e_rdn = e_rdn; v.e_rdd = e_rdd;
        v.e_cnt = e_cnt; v.e_full = e_full; v.e_af = e_af; v.e_empty = e_empty;
        return v;
    endfunction

    vec_t tbl [19];
    logic [7:0] q [$];

    initial begin
        // wv wn wd rr dr fl | wr_ready rd_num rd_data | count full af empty (after edge)
        tbl[0]  = mk(1, 4, 32'h03020100, 0, 0, 0, 1, 0, 32'h0,        4,  0, 0, 0);
        tbl[1]  = mk(1, 4, 32'h07060504, 0, 0, 0, 1, 4, 32'h03020100, 8,  0, 0, 0);
        tbl[2]  = mk(1, 4, 32'h0b0a0908, 0, 0, 0, 1, 4, 32'h03020100, 12, 0, 1, 0);
        tbl[3]  = mk(1, 4, 32'h0f0e0d0c, 0, 0, 0, 1, 4, 32'h03020100, 16, 1, 1, 0);
        tbl[4]  = mk(1, 1, 32'h000000aa, 0, 0, 0, 0, 4, 32'h03020100, 16, 1, 1, 0);
        tbl[5]  = mk(0, 0, 32'h0,        1, 0, 0, 1, 4, 32'h03020100, 12, 0, 1, 0);
        tbl[6]  = mk(0, 0, 32'h0,        1, 0, 0, 1, 4, 32'h07060504, 8,  0, 0, 0);
        tbl[7]  = mk(1, 3, 32'h00121110, 1, 0, 0, 1, 4, 32'h0b0a0908, 7,  0, 0, 0);
        tbl[8]  = mk(1, 4, 32'h17161514, 0, 0, 0, 1, 4, 32'h0f0e0d0c, 11, 0, 0, 0);
        tbl[9]  = mk(1, 3, 32'h001a1918, 0, 0, 0, 1, 4, 32'h0f0e0d0c, 14, 0, 1, 0);
        tbl[10] = mk(1, 4, 32'h1e1d1c1b, 1, 0, 0, 0, 4, 32'h0f0e0d0c, 10, 0, 0, 0);
        tbl[11] = mk(0, 0, 32'h0,        1, 0, 0, 1, 4, 32'h14121110, 6,  0, 0, 0);
        tbl[12] = mk(0, 0, 32'h0,        1, 0, 0, 1, 4, 32'h18171615, 2,  0, 0, 0);
        tbl[13] = mk(0, 0, 32'h0,        1, 0, 0, 1, 0, 32'h0,        2,  0, 0, 0);
        tbl[14] = mk(0, 0, 32'h0,        0, 1, 0, 1, 2, 32'h00001a19, 2,  0, 0, 0);
        tbl[15] = mk(0, 0, 32'h0,        1, 1, 0, 1, 2, 32'h00001a19, 0,  0, 0, 1);
        tbl[16] = mk(1, 2, 32'h00003130, 0, 0, 0, 1, 0, 32'h0,        2,  0, 0, 0);
        tbl[17] = mk(1, 4, 32'hdeadbeef, 1, 0, 1, 1, 0, 32'h0,        0,  0, 0, 1);
        tbl[18] = mk(0, 0, 32'h0,        0, 1, 0, 1, 0, 32'h0,        0,  0, 0, 1);

        // Reset then idle
        sel = 0;
        do_reset();
        wr_num = 4;
        #1;
        chk("rst_count", m_cnt, 0);
        chk("rst_empty", m_empty, 1);
        chk("rst_full", m_full, 0);
        chk("rst_af", m_af, 0);
        chk("rst_rd_valid", m_rdv, 0);
        chk("rst_rd_num", m_rdn, 0);
        chk("rst_rd_data", m_rdd, 0);
        chk("rst_wr_ready", m_wrr, 1);
        chk("rst_err", m_err, 0);

        // Vector table on SIZE=16
        for (int i = 0; i < 19; i++) begin
            wr_valid = tbl[i].wv; wr_num = tbl[i].wn; wr_data = tbl[i].wd;
            rd_ready = tbl[i].rr; drain = tbl[i].dr; flush = tbl[i].fl;
            #1;
            chk($sformatf("vec%0d_wr_ready", i), m_wrr, tbl[i].e_wrr);
            chk($sformatf("vec%0d_rd_num", i), m_rdn, tbl[i].e_rdn);
            chk($sformatf("vec%0d_rd_data", i), m_rdd, tbl[i].e_rdd);
            tick();
            chk($sformatf("vec%0d_count", i), m_cnt, tbl[i].e_cnt);
            chk($sformatf("vec%0d_full", i), m_full, tbl[i].e_full);
            chk($sformatf("vec%0d_af", i), m_af, tbl[i].e_af);
            chk($sformatf("vec%0d_empty", i), m_empty, tbl[i].e_empty);
        end
        idle();

        // Drain a partial beat of 3 words
        do_reset();
        put(3, 32'h000c0b0a);
        #1;
        chk("drain0_rd_valid", m_rdv, 0);
        drain = 1;
        #1;
        chk("drain1_rd_num", m_rdn, 3);
        chk("drain1_rd_data", m_rdd, 32'h000c0b0a);
        rd_ready = 1;
        tick();
        idle();
        chk("drain_empty", m_empty, 1);

        // Illegal writes, err stickiness across flush, reset mid-transfer
        put(2, 32'h00002221);
        put(0, 32'h11111111);
        chk("illegal0_err", m_err, 1);
        chk("illegal0_count", m_cnt, 2);
        put(5, 32'h11111111);
        chk("illegal5_count", m_cnt, 2);
        flush = 1;
        tick();
        flush = 0;
        chk("flush_err_kept", m_err, 1);
        chk("flush_count", m_cnt, 0);
        put(4, 32'h44434241);
        wr_valid = 1; wr_num = 4; rd_ready = 1; rst = 1;
        tick();
        rst = 0;
        idle();
        chk("midrst_count", m_cnt, 0);
        chk("midrst_err", m_err, 0);
        chk("midrst_rd_valid", m_rdv, 0);

        // Wrap on SIZE=12
        sel = 1;
        do_reset();
        put(4, 32'h03020100);
        put(4, 32'h07060504);
        put(4, 32'h0b0a0908);
        chk("w12_full", m_full, 1);
        rd_ready = 1;
        tick();
        tick();
        rd_ready = 0;
        put(4, 32'h0f0e0d0c);
        put(4, 32'h13121110);
        rd_ready = 1;
        #1;
        chk("w12_beat0", m_rdd, 32'h0b0a0908);
        tick();
        chk("w12_beat1", m_rdd, 32'h0f0e0d0c);
        tick();
        chk("w12_beat2", m_rdd, 32'h13121110);
        tick();
        idle();
        chk("w12_empty", m_empty, 1);

        // Random traffic against a queue model, both sizes
        for (int s = 0; s < 2; s++) begin
            int   size, cnt, r;
            logic merr;
            logic [2:0]  e_rdn;
            logic [31:0] e_rdd;
            logic e_wrr, wfire, rfire;
            sel = s;
            size = (s == 0) ? 16 : 12;
            do_reset();
            q.delete();
            merr = 0;
            for (int c = 0; c < 800; c++) begin
                r = int'($urandom % 20);
                wr_num   = (r == 0) ? 3'd0 : (r == 1) ? 3'd5 : 3'($urandom_range(1, 4));
                wr_valid = ($urandom % 4) != 0;
                wr_data  = $urandom;
                rd_ready = ($urandom % 3) != 0;
                drain    = ($urandom % 4) == 0;
                flush    = ($urandom % 40) == 0;
                rst      = ($urandom % 150) == 0;
                #1;
                cnt   = q.size();
                e_wrr = (size - cnt) >= int'(wr_num);
                e_rdn = (cnt >= 4) ? 3'd4 : (drain ? 3'(cnt) : 3'd0);
                e_rdd = 0;
                for (int j = 0; j < int'(e_rdn); j++) e_rdd[8*j +: 8] = q[j];
                chk($sformatf("rnd%0d_%0d_wr_ready", s, c), m_wrr, e_wrr);
                chk($sformatf("rnd%0d_%0d_rd_num", s, c), m_rdn, e_rdn);
                chk($sformatf("rnd%0d_%0d_rd_valid", s, c), m_rdv, e_rdn != 0);
                chk($sformatf("rnd%0d_%0d_rd_data", s, c), m_rdd, e_rdd);
                chk($sformatf("rnd%0d_%0d_count", s, c), m_cnt, cnt);
                chk($sformatf("rnd%0d_%0d_flags", s, c), {m_full, m_empty, m_af},
                    {cnt == size, cnt == 0, cnt >= size - 4});
                chk($sformatf("rnd%0d_%0d_err", s, c), m_err, merr);
                wfire = wr_valid && e_wrr && wr_num >= 1 && wr_num <= 4;
                rfire = rd_ready && e_rdn != 0;
                if (rst) begin
                    q.delete();
                    merr = 0;
                end else begin
                    if (wr_valid && (wr_num == 0 || wr_num > 4)) merr = 1;
                    if (flush) q.delete();
                    else begin
                        if (rfire) repeat (int'(e_rdn)) void'(q.pop_front());
                        if (wfire) for (int j = 0; j < int'(wr_num); j++) q.push_back(wr_data[8*j +: 8]);
                    end
                end
                tick();
            end
            rst = 0;
            idle();
            chk($sformatf("rnd%0d_final_count", s), m_cnt, q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
